// File: rtl/arm_mem_system.sv
`default_nettype none
// ============================================================================
// Module      : arm_mem_system
// Description : Memory subsystem behind the single memory port of the
//               multicycle ARM core. Unified instruction/data RAM, a
//               free-running cycle timer with compare/match flag, and a
//               byte-wide transmit FIFO drained through a valid/ready port.
//               Reads are combinational; all writes commit on the rising edge.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               MemWrite, Adr,        - core memory port (Adr[1:0] ignored)
//               WriteData, ReadData
//               tx_data, tx_valid,    - FIFO head byte / not-empty / consumer
//               tx_ready                accept
//               irq                   - timer match flag
// Revision    : 1.0 - initial release
// ============================================================================
module arm_mem_system #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int c_AW = $clog2(RAM_WORDS);
    localparam int c_PW = $clog2(FIFO_DEPTH);

    // MMIO word offsets (Adr[15:2])
    localparam logic [13:0] c_OFF_COUNT = 14'h0000;
    localparam logic [13:0] c_OFF_CMP   = 14'h0001;
    localparam logic [13:0] c_OFF_STAT  = 14'h0002;
    localparam logic [13:0] c_OFF_TXD   = 14'h0004;
    localparam logic [13:0] c_OFF_TXS   = 14'h0005;

    localparam logic [c_PW:0]   c_DEPTH   = (c_PW+1)'(FIFO_DEPTH);
    localparam logic [c_PW:0]   c_CNT_ONE = (c_PW+1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic            w_is_mmio;
    logic [13:0]     w_off;
    logic [c_AW-1:0] w_widx;
    logic            w_unused;

    assign w_is_mmio = (Adr[31:16] == 16'hFFFF);
    assign w_off     = Adr[15:2];
    assign w_widx    = Adr[c_AW+1:2];
    assign w_unused  = ^Adr[1:0];

    logic w_wr_mmio;
    logic w_wr_count;
    logic w_wr_cmp;
    logic w_wr_stat;
    logic w_wr_txd;
    logic w_wr_txs;

    assign w_wr_mmio  = MemWrite && w_is_mmio;
    assign w_wr_count = w_wr_mmio && (w_off == c_OFF_COUNT);
    assign w_wr_cmp   = w_wr_mmio && (w_off == c_OFF_CMP);
    assign w_wr_stat  = w_wr_mmio && (w_off == c_OFF_STAT);
    assign w_wr_txd   = w_wr_mmio && (w_off == c_OFF_TXD);
    assign w_wr_txs   = w_wr_mmio && (w_off == c_OFF_TXS);

    // ------------------------------------------------------------------------
    // RAM: contents survive reset, but a write in the reset cycle is dropped
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && MemWrite && !w_is_mmio) begin
            r_mem[w_widx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------------
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_wr_count ? WriteData : (r_count + 32'd1);
            if (w_wr_cmp) begin
                r_cmp <= WriteData;
            end
            // A match on the pre-edge count takes priority over a clear
            if (r_count == r_cmp) begin
                r_flag <= 1'b1;
            end else if (w_wr_stat && WriteData[0]) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign irq = r_flag;

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]      r_buf [FIFO_DEPTH];
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [c_PW:0]   r_cnt;
    logic            r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == c_DEPTH);
    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_buf[r_rd];
    assign w_pop    = tx_valid && tx_ready;
    // A full FIFO still accepts when the head leaves on the same edge
    assign w_push   = w_wr_txd && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_buf[r_wr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_ONE;
            end
            if (w_push) begin
                r_wr <= r_wr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            // Sticky overflow: a dropped byte wins over a same-cycle clear
            if (w_wr_txd && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_txs && WriteData[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    logic [7:0] w_cnt8;
    assign w_cnt8 = 8'(r_cnt);

    always_comb begin
        ReadData = 32'd0;
        if (w_is_mmio) begin
            case (w_off)
                c_OFF_COUNT: ReadData = r_count;
                c_OFF_CMP:   ReadData = r_cmp;
                c_OFF_STAT:  ReadData = {31'd0, r_flag};
                c_OFF_TXS:   ReadData = {16'd0, w_cnt8, 5'd0, r_ovf, w_empty, w_full};
                default:     ReadData = 32'd0;
            endcase
        end else begin
            ReadData = r_mem[w_widx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_mem_system
// Description : Self-checking bench for arm_mem_system. Address/data vectors
//               from a table, hand-written timer and FIFO sequences, and a
//               byte scoreboard checked on every FIFO pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_mem_system;

    localparam logic [31:0] c_COUNT = 32'hFFFF_0000;
    localparam logic [31:0] c_CMP   = 32'hFFFF_0004;
    localparam logic [31:0] c_STAT  = 32'hFFFF_0008;
    localparam logic [31:0] c_TXD   = 32'hFFFF_0010;
    localparam logic [31:0] c_TXS   = 32'hFFFF_0014;
    localparam logic [31:0] c_UNMAP = 32'hFFFF_0020;
    localparam int          c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_exp[$];

    arm_mem_system #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] radr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        Adr       = a;
        WriteData = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference FIFO: the byte is kept if the pre-edge occupancy has room or
    // the head is popped on the same edge.
    task automatic push_byte(input logic [7:0] b);
        if (q_exp.size() < c_DEPTH || (tx_ready && q_exp.size() > 0)) begin
            q_exp.push_back(b);
        end
        drive(1'b1, c_TXD, {24'd0, b});
        step();
    endtask

    // Scoreboard: every handshake must present the oldest expected byte
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (q_exp.size() == 0) begin
                chk("tx_pop_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_data", {24'd0, tx_data}, {24'd0, q_exp.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0008, 32'hDEAD_BEEF, "ram_wr_rd"};
        vecs[1] = '{1'b0, 32'h0,         32'h0,         32'h0000_0108, 32'hDEAD_BEEF, "ram_alias_rd"};
        vecs[2] = '{1'b1, 32'h0000_001C, 32'h1234_5678, 32'h0000_001C, 32'h1234_5678, "ram_wr2"};
        vecs[3] = '{1'b1, 32'h0FF0_001C, 32'hA5A5_5A5A, 32'h0000_001C, 32'hA5A5_5A5A, "ram_alias_wr"};
        vecs[4] = '{1'b1, c_UNMAP,       32'hFFFF_FFFF, c_UNMAP,       32'h0,         "unmapped_rd"};
        vecs[5] = '{1'b1, c_UNMAP,       32'h0000_00FF, c_TXS,         32'h0000_0002, "unmapped_wr_txs"};
        vecs[6] = '{1'b0, 32'h0,         32'h0,         c_TXD,         32'h0,         "txd_rd"};
        vecs[7] = '{1'b1, c_CMP,         32'h0000_1234, c_CMP,         32'h0000_1234, "cmp_wr_rd"};

        reset    = 1'b1;
        tx_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;

        // ---------------- reset state ----------------
        drive(1'b0, c_COUNT, 32'h0);
        @(negedge clk);
        chk("rst_count", ReadData, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
        drive(1'b0, c_CMP, 32'h0);
        #1 chk("rst_cmp", ReadData, 32'hFFFF_FFFF);
        drive(1'b0, c_TXS, 32'h0);
        #1 chk("rst_txs", ReadData, 32'h0000_0002);
        step();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) begin
                drive(1'b1, vecs[i].adr, vecs[i].wdata);
                step();
            end
            drive(1'b0, vecs[i].radr, 32'h0);
            @(negedge clk);
            chk(vecs[i].name, ReadData, vecs[i].exp);
            step();
        end

        // ---------------- timer ----------------
        drive(1'b1, c_CMP, 32'd20);
        step();
        drive(1'b1, c_COUNT, 32'd15);
        step();
        drive(1'b0, c_COUNT, 32'h0);
        @(negedge clk);
        chk("count_load", ReadData, 32'd15);
        step();
        @(negedge clk);
        chk("count_inc", ReadData, 32'd16);
        step();
        step();
        step();
        step();
        @(negedge clk);
        chk("count_at_cmp", ReadData, 32'd20);
        chk("irq_before_match", {31'd0, irq}, 32'h0);
        step();
        drive(1'b1, c_STAT, 32'h1);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, 32'h1);
        step();
        drive(1'b1, c_COUNT, 32'd19);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        step();
        drive(1'b0, c_COUNT, 32'h0);
        @(negedge clk);
        chk("count_reload", ReadData, 32'd19);
        step();
        drive(1'b1, c_STAT, 32'h1);
        @(negedge clk);
        chk("irq_match_cycle", {31'd0, irq}, 32'h0);
        step();
        drive(1'b0, c_STAT, 32'h0);
        @(negedge clk);
        chk("irq_set_wins", {31'd0, irq}, 32'h1);
        chk("stat_flag", ReadData, 32'h1);
        step();
        drive(1'b1, c_STAT, 32'h1);
        step();

        // ---------------- FIFO overflow and drain ----------------
        tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) begin
            push_byte(8'(b));
        end
        drive(1'b0, c_TXS, 32'h0);
        @(negedge clk);
        chk("txs_full_ovf", ReadData, 32'h0000_0405);
        chk("tx_head_hold", {24'd0, tx_data}, 32'h41);
        step();
        drive(1'b1, c_TXS, 32'h4);
        step();
        drive(1'b0, c_TXS, 32'h0);
        @(negedge clk);
        chk("txs_ovf_clear", ReadData, 32'h0000_0401);
        step();
        tx_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drain_valid", {31'd0, tx_valid}, 32'h0);
        chk("drain_txs", ReadData, 32'h0000_0002);
        chk("drain_sb_empty", 32'(q_exp.size()), 32'h0);
        step();

        // ---------------- push into full FIFO with same-cycle pop ----------------
        tx_ready = 1'b0;
        for (int b = 8'h61; b <= 8'h64; b++) begin
            push_byte(8'(b));
        end
        tx_ready = 1'b1;
        push_byte(8'h55);
        tx_ready = 1'b0;
        drive(1'b0, c_TXS, 32'h0);
        @(negedge clk);
        chk("txs_push_pop_full", ReadData, 32'h0000_0401);
        step();
        tx_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drain2_sb_empty", 32'(q_exp.size()), 32'h0);
        chk("drain2_valid", {31'd0, tx_valid}, 32'h0);
        step();

        // ---------------- reset mid-operation ----------------
        tx_ready = 1'b0;
        push_byte(8'h71);
        push_byte(8'h72);
        push_byte(8'h73);
        drive(1'b1, c_CMP, 32'd50);
        step();
        drive(1'b1, c_COUNT, 32'd50);
        step();
        drive(1'b0, c_COUNT, 32'h0);
        step();
        @(negedge clk);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        chk("pre_rst_valid", {31'd0, tx_valid}, 32'h1);
        step();
        reset = 1'b1;
        q_exp.delete();
        drive(1'b1, 32'h0000_0008, 32'h0BAD_F00D);
        step();
        reset = 1'b0;
        drive(1'b0, c_COUNT, 32'h0);
        @(negedge clk);
        chk("post_rst_valid", {31'd0, tx_valid}, 32'h0);
        chk("post_rst_irq", {31'd0, irq}, 32'h0);
        chk("post_rst_count", ReadData, 32'h0);
        step();
        drive(1'b0, 32'h0000_0008, 32'h0);
        @(negedge clk);
        chk("post_rst_ram", ReadData, 32'hDEAD_BEEF);
        drive(1'b0, c_TXS, 32'h0);
        #1 chk("post_rst_txs", ReadData, 32'h0000_0002);
        drive(1'b0, c_CMP, 32'h0);
        #1 chk("post_rst_cmp", ReadData, 32'hFFFF_FFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_mem_system.md
# arm_mem_system

Memory subsystem on the single memory port of the multicycle ARM core. It holds a unified instruction/data RAM, a memory-mapped cycle timer with compare flag, and a byte-wide transmit FIFO that drains through a valid/ready port. Reads are combinational, so the core can sample ReadData in the same cycle it drives Adr. Writes commit on the rising clock edge.

## Interface
- RAM_WORDS, default 64: RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, default 4: TX FIFO depth in bytes; power of 2, minimum 2.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  write strobe from the core.
- Adr  in  32  byte address from the core; bits [1:0] are ignored.
- WriteData  in  32  store data from the core.
- ReadData  out  32  combinational read data for Adr.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- irq  out  1  equals the timer match flag.

## Operation
- Decode: Adr[31:16]==16'hFFFF selects MMIO. Any other address selects RAM at word index Adr[log2(RAM_WORDS)+1:2]. Higher address bits alias.
- MMIO map (offset = Adr[15:0]):
  - 0x0000 COUNT: R/W. A write loads the counter.
  - 0x0004 CMP: R/W.
  - 0x0008 STAT: bit0 is the match flag. Writing 1 to bit0 clears it.
  - 0x0010 TXD: write only; pushes WriteData[7:0]. Reads return 0.
  - 0x0014 TXS: read returns {count[..]@bits[15:8], overflow@bit2, empty@bit1, full@bit0}. Writing 1 to bit2 clears overflow.
  - Unmapped MMIO offsets read 0 and ignore writes.
- RAM: a write with MemWrite=1 updates the whole word. Reset does not affect RAM contents.
- Timer:
  - The counter increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A COUNT write loads WriteData instead of incrementing in that cycle.
  - When the pre-edge COUNT equals CMP, the flag sets at that edge.
  - A simultaneous set and STAT clear leaves the flag set (set wins).
- FIFO:
  - Pop occurs when tx_valid&&tx_ready.
  - A TXD write is accepted if the pre-edge count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A write that is not accepted drops the byte and sets sticky overflow. FIFO contents are unchanged.
  - A simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - COUNT=0, CMP=0xFFFFFFFF, flag=0, irq=0.
  - FIFO empty (tx_valid=0, tx_data=0 while empty), overflow=0.
  - ReadData follows Adr immediately.
- Reset mid-operation discards FIFO contents and pending flags in the same edge. Writes in the reset cycle are ignored, including RAM writes.
- Read latency is 0 cycles (combinational). A write is visible to reads from the cycle after the edge.
- A pushed byte appears on tx_data/tx_valid in the cycle after the push edge. tx_data holds stable while tx_valid=1 and tx_ready=0.
- A COUNT read returns the pre-edge value. After a COUNT write of V, the next cycle reads V, then V+1.
- Match timing: with CMP=C, the flag and irq rise in the cycle after COUNT reads C.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0000_0008 and read 0x0000_0008 -> 0xDEADBEEF. Reading 0x0000_0108 with RAM_WORDS=64 -> 0xDEADBEEF (alias).
- Write CMP=20, then COUNT=15 -> COUNT reads 16 one cycle later. irq rises the cycle after COUNT=20. A STAT write of 1 clears irq next cycle. Clear issued in the match cycle -> irq stays 1.
- With tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 (FIFO_DEPTH=4) -> TXS reads full=1, overflow=1, count=4. Raise tx_ready -> tx_data sequence is 0x41..0x44, then tx_valid=0 and empty=1.
- FIFO full, tx_ready=1, TXD write 0x55 in the same cycle -> accepted, count stays 4, overflow stays 0. 0x55 emerges last.
- Reads of MMIO 0xFFFF0020 -> 0, and TXD reads -> 0. A write to 0xFFFF0020 -> no state change.
- Assert reset for one cycle with 3 bytes queued and flag=1 -> next cycle tx_valid=0, irq=0, COUNT reads 0, and RAM contents are preserved.
